bta4_ternary_adder: RTL and testbench
=====================================

Name: bta4_ternary_adder

Overview:
- Balanced-ternary adder with a byte-wide I/O wrapper.
- Adds two 2-trit balanced-ternary operands, X and Y, packed into an 8-bit input.
- Returns the 3-trit sum, plus one spare trit, packed into an 8-bit output.
- Sits as a standalone user tile behind an 8-in/8-out pin interface; output is registered.

Parameters:
- None. Widths are fixed by the 8-bit pin interface.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- io_in  input  8  packed operands: [7:6]=y0, [5:4]=y1, [3:2]=x0, [1:0]=x1.
- io_out  output  8  packed sum: [7:6]=s0, [5:4]=s1, [3:2]=s2, [1:0]=s3 (spare/status trit).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Trit encoding (2 bits, MSB:LSB):
  - 01 = -1
  - 11 = 0
  - 10 = +1
  - 00 = illegal; decoded as 0.
- Operand and sum values (index 0 = least significant trit):
  - X = x0 + 3*x1, Y = y0 + 3*y1; range -4..+4 each.
  - S = X + Y, range -8..+8; represented exactly as s0 + 3*s1 + 9*s2.
- Arithmetic: trit-serial ripple using a balanced-ternary full adder.
  - Per stage: a + b + cin, each in {-1,0,+1}; sum trit in {-1,0,+1}; carry in {-1,0,+1}.
  - Stage 0: cin = 0.
  - s2 = final carry out of stage 1.
- s3: always encoded 11 (zero) in the base build.
- Timing:
  - io_out is a register loaded from the combinational result every cycle.
  - Latency: exactly 1 clock. Output reflects io_in sampled at the previous rising edge.
  - No handshake; a new operand is accepted every cycle.
- Reset:
  - While rst=1 at a rising edge, io_out <= 8'hFF (all trits zero).
  - rst has priority over the data load. The first valid result appears one cycle after rst deasserts.
  - Asserting rst mid-stream discards the pending result.
- Illegal code 00 in any input trit is treated as 0 for arithmetic. The output never contains code 00 except via the optional feature.

Optional Feature:
- Macro: BTA4_ILLEGAL_FLAG_EN.
- Defined:
  - io_out[1:0] = 00 in the cycle following any input trit equal to 00; otherwise 11.
  - Arithmetic is unchanged (illegal trits still count as 0).
  - Reset value of io_out is still 8'hFF.
- Undefined: io_out[1:0] is constant 11.

Decomposition:
- Shared package bta4_pkg holds:
  - trit encoding constants: TRIT_NEG=2'b01, TRIT_ZERO=2'b11, TRIT_POS=2'b10, TRIT_ILL=2'b00;
  - a signed 2-bit trit value typedef;
  - decode/encode functions (code <-> signed value).
- One sub-module: bt_full_adder. Inputs a, b, cin as encoded trits; outputs sum and cout as encoded trits.
- Top instantiates two bt_full_adder stages plus the output register.

Test Plan:
- Reset: rst=1, any io_in -> io_out=8'hFF; after rst=0 with io_in=8'h55 -> io_out=8'hB7 one cycle later.
- Min sum, (-4)+(-4)=-8: io_in=8'h55 -> io_out=8'hB7 (s0=+1, s1=0, s2=-1).
- Max sum, (+4)+(+4)=+8: io_in=8'hAA -> io_out=8'h7B (s0=-1, s1=0, s2=+1).
- Carry, (+1)+(+1)=+2: io_in=8'hBB -> io_out=8'h6F (s0=-1, s1=+1, s2=0).
- Cancellation, (+1)+(-1)=0: io_in=8'hB7 -> io_out=8'hFF; zero operands io_in=8'hFF -> io_out=8'hFF.
- Illegal input, io_in=8'h00:
  - without BTA4_ILLEGAL_FLAG_EN -> io_out=8'hFF;
  - with BTA4_ILLEGAL_FLAG_EN -> io_out=8'hFC.
  - Back-to-back changes each cycle confirm 1-cycle latency.

Source files
------------

// File: rtl/bta4_pkg.sv
// Shared definitions for the 2-trit balanced-ternary adder tile.
// Trit encoding (MSB:LSB): 01 = -1, 11 = 0, 10 = +1, 00 = illegal (read as 0).
package bta4_pkg;

    localparam logic [1:0] TRIT_NEG  = 2'b01;
    localparam logic [1:0] TRIT_ZERO = 2'b11;
    localparam logic [1:0] TRIT_POS  = 2'b10;
    localparam logic [1:0] TRIT_ILL  = 2'b00;

    // Signed two's-complement value of one trit; only -1, 0 and +1 are used.
    typedef logic signed [1:0] trit_val_t;

    // Encoded trit code to signed value; the illegal code reads as zero.
    function automatic trit_val_t trit_decode(input logic [1:0] code);
        trit_val_t v;
        case (code)
            TRIT_NEG: v = -2'sd1;
            TRIT_POS: v = 2'sd1;
            default:  v = 2'sd0;
        endcase
        return v;
    endfunction

    // Signed value to encoded trit code; out-of-range values map to zero
    // so that the illegal code can never be produced here.
    function automatic logic [1:0] trit_encode(input trit_val_t v);
        logic [1:0] code;
        case (v)
            2'b11:   code = TRIT_NEG;
            2'b01:   code = TRIT_POS;
            default: code = TRIT_ZERO;
        endcase
        return code;
    endfunction

    // True when a trit carries the illegal code.
    function automatic logic trit_is_illegal(input logic [1:0] code);
        return code == TRIT_ILL;
    endfunction

endpackage

// File: rtl/bta4_ternary_adder_bt_full_adder.sv
// Balanced-ternary full adder: sum + 3*cout = a + b + cin, all trits encoded.
import bta4_pkg::*;

module bt_full_adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] cin,
    output logic [1:0] sum,
    output logic [1:0] cout
);

    logic signed [2:0] total;
    logic signed [2:0] sum_wide;
    trit_val_t         sum_v;
    trit_val_t         cout_v;
    trit_val_t         a_v;
    trit_val_t         b_v;
    trit_val_t         c_v;

    // Add the three digits (range -3..+3) and fold into one trit plus a carry.
    always_comb begin
        a_v      = trit_decode(a);
        b_v      = trit_decode(b);
        c_v      = trit_decode(cin);
        total    = {a_v[1], a_v} + {b_v[1], b_v} + {c_v[1], c_v};
        sum_wide = total;
        cout_v   = 2'sd0;
        if (total > 3'sd1) begin
            sum_wide = total - 3'sd3;
            cout_v   = 2'sd1;
        end else if (total < -3'sd1) begin
            sum_wide = total + 3'sd3;
            cout_v   = -2'sd1;
        end
        sum_v = sum_wide[1:0];
        sum   = trit_encode(sum_v);
        cout  = trit_encode(cout_v);
    end

endmodule

// File: rtl/bta4_ternary_adder.sv
// Byte-wide balanced-ternary adder tile: S = X + Y with X, Y in -4..+4.
// io_in  = {y0, y1, x0, x1}, io_out = {s0, s1, s2, s3}, 1-cycle registered.
// Optional macro BTA4_ILLEGAL_FLAG_EN: s3 reads 00 in the cycle after any
// input trit carried the illegal code; otherwise s3 is always zero (11).
// There is no handshake: every rising edge samples io_in and the result of
// that sample is visible on io_out until the next rising edge.
import bta4_pkg::*;

module bta4_ternary_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic [1:0] x0;
    logic [1:0] x1;
    logic [1:0] y0;
    logic [1:0] y1;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] s3;
    logic [1:0] carry0;
    logic [7:0] io_out_d;
    logic [7:0] io_out_q;

    // Unpack operand trits from the pin byte.
    always_comb begin
        y0 = io_in[7:6];
        y1 = io_in[5:4];
        x0 = io_in[3:2];
        x1 = io_in[1:0];
    end

    bt_full_adder u_stage0 (
        .a    (x0),
        .b    (y0),
        .cin  (TRIT_ZERO),
        .sum  (s0),
        .cout (carry0)
    );

    // The carry out of the top stage is the third sum trit.
    bt_full_adder u_stage1 (
        .a    (x1),
        .b    (y1),
        .cin  (carry0),
        .sum  (s1),
        .cout (s2)
    );

`ifdef BTA4_ILLEGAL_FLAG_EN
    // Spare trit flags any illegal input code; arithmetic already reads it as 0.
    always_comb begin
        s3 = TRIT_ZERO;
        if (trit_is_illegal(x0) || trit_is_illegal(x1) ||
            trit_is_illegal(y0) || trit_is_illegal(y1)) begin
            s3 = TRIT_ILL;
        end
    end
`else
    // Spare trit is unused and held at zero.
    always_comb begin
        s3 = TRIT_ZERO;
    end
`endif

    // Pack the next output byte.
    always_comb begin
        io_out_d = {s0, s1, s2, s3};
    end

    // Output register; reset forces all-zero trits and drops the pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_out_q <= 8'hFF;
        end else begin
            io_out_q <= io_out_d;
        end
    end

    assign io_out = io_out_q;

endmodule

// File: tb/tb_bta4_ternary_adder.sv
// Directed bench for bta4_ternary_adder with hand-computed expected bytes.
module tb_bta4_ternary_adder;

    logic       clk;
    logic       rst;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef BTA4_ILLEGAL_FLAG_EN
    localparam logic [7:0] EXP_ILL_ZERO = 8'hFC;
`else
    localparam logic [7:0] EXP_ILL_ZERO = 8'hFF;
`endif

    bta4_ternary_adder dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: io_out=%02h expected=%02h", tag, obs, exp);
    endtask

    // Drive one operand byte before the edge, check 1 ns after the edge.
    task automatic step(input string tag, input logic [7:0] din, input logic [7:0] exp);
        io_in = din;
        @(posedge clk);
        #1;
        check(tag, io_out, exp);
    endtask

    initial begin
        rst   = 1'b1;
        io_in = 8'hAA;

        // Reset with several operand patterns present.
        @(posedge clk); #1;
        check("reset_aa", io_out, 8'hFF);
        step("reset_rand", 8'($urandom_range(0, 255)), 8'hFF);
        step("reset_55", 8'h55, 8'hFF);

        // First result one cycle after release.
        rst = 1'b0;
        step("first_min", 8'h55, 8'hB7);

        // Back-to-back vectors, a new one every cycle.
        step("max_sum", 8'hAA, 8'h7B);
        step("carry", 8'hBB, 8'h6F);
        step("cancel", 8'hB7, 8'hFF);
        step("zero", 8'hFF, 8'hFF);
        step("mixed_5", 8'h6E, 8'h5B);
        step("min_sum", 8'h55, 8'hB7);

        // Output must hold until the next edge after an input change.
        io_in = 8'hAA;
        #2;
        check("hold", io_out, 8'hB7);
        @(posedge clk); #1;
        check("hold_next", io_out, 8'h7B);

        // Illegal codes read as zero; flag build marks the spare trit.
        step("illegal_all", 8'h00, EXP_ILL_ZERO);
        step("illegal_one", 8'h3F, EXP_ILL_ZERO);
        step("legal_after", 8'hBB, 8'h6F);

        // Mid-stream reset discards the pending result.
        rst = 1'b1;
        step("mid_reset", 8'h55, 8'hFF);
        rst = 1'b0;
        step("post_reset", 8'hAA, 8'h7B);
        step("post_reset2", 8'hFF, 8'hFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
